multiword_adder_sequencer: RTL and testbench
============================================

Name: multiword_adder_sequencer

Overview:
- Sequences one shared combinational `sixtyfour_bit_adder` to add or subtract wide operands, 64 bits per cycle, ripple-carrying through a carry register.
- Sits between a requester, on a valid/ready handshake, and the adder instance.
- The adder is instantiated outside this block; its A/B/Cin/S/Cout connect through the `add_*` ports.
- Used wherever operands wider than 64 bits are needed without replicating the adder.

Parameters:
- WORDS, 4, number of 64-bit words per operand (≥2); operand width W = 64*WORDS.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- op_cin  in  1  carry-in for add; ignored for subtract.
- op_sub  in  1  1 = compute A − B, 0 = compute A + B + cin.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- res_sum  out  W  result.
- res_cout  out  1  final carry-out (subtract: 1 = no borrow).
- add_a  out  64  to adder A.
- add_b  out  64  to adder B.
- add_cin  out  1  to adder Cin.
- add_s  in  64  from adder S.
- add_cout  in  1  from adder Cout.

Behaviour:
- Reset (rst_n=0 at posedge, overrides everything):
  - state=IDLE, in_ready=1, out_valid=0, res_sum=0, res_cout=0.
  - Internal word index=0, carry register=0, operand registers=0.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is produced.
- Operand registers and add_* drive:
  - add_a/add_b/add_cin are combinational from registered operands, the word index and the carry register.
  - In IDLE and DONE they drive 0/0/0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at posedge: latch op_a, latch op_b (stored as ~op_b when op_sub=1).
  - Carry register ← (op_sub ? 1 : op_cin).
  - Word index ← 0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle, word k = index is presented: add_a=A[64k+63:64k], add_b=B'[64k+63:64k], add_cin=carry register.
  - At posedge: res_sum[64k+63:64k] ← add_s; carry ← add_cout; index ← index+1.
  - When index = WORDS−1: res_cout ← add_cout and go to DONE.
- DONE:
  - out_valid=1; res_sum and res_cout are held stable.
  - On out_ready=1 at posedge: out_valid ← 0 and go to IDLE.
  - No new request is accepted before the result is consumed.
- Latency:
  - Request accepted at edge T; out_valid=1 from edge T+WORDS.
  - Minimum request interval is WORDS+2 cycles (the in_ready=1 IDLE cycle is required between operations).
- Arithmetic:
  - Modulo 2^W.
  - Subtract uses two's complement: A + ~B + 1.
  - res_cout is the carry out of the top word.
- Word index width: clog2(WORDS).
- res_sum words not yet written in the current operation hold their previous values. Consumers only read when out_valid=1.
- add_s is only sampled in RUN.

Test Plan:
1. WORDS=4, A=0, B=all 0xAA…AA, cin=0, add → res_sum=0xAA…AA, res_cout=0; out_valid rises exactly 4 cycles after accept.
2. A=B=all ones, cin=0 → res_sum=0xFFFF…FFFE, res_cout=1; repeat with cin=1 → res_sum=all ones, res_cout=1.
3. A=0x0000…0001_FFFF_FFFF_FFFF_FFFF (word0 all ones, word1=1), B=1, add → word0=0, word1=2, words2–3=0, res_cout=0 (checks inter-word carry).
4. Subtract A=0, B=1 → res_sum=all ones, res_cout=0; subtract A=5, B=3 → res_sum=2, res_cout=1.
5. Hold out_ready=0 for 10 cycles in DONE → out_valid, res_sum and in_ready=0 held; a new in_valid pulse is ignored; out_ready=1 → IDLE next cycle.
6. Assert rst_n=0 during RUN at word 2 → next cycle IDLE, out_valid=0, res_sum=0; a fresh add of 1+1 then yields 2.

Source files
------------

// File: rtl/multiword_adder_sequencer.sv
// Multi-word add/subtract sequencer: drives one shared external 64-bit adder
// one word per cycle, rippling the carry through a register.
module multiword_adder_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [64*WORDS-1:0] op_a,
    input  logic [64*WORDS-1:0] op_b,
    input  logic                op_cin,
    input  logic                op_sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [64*WORDS-1:0] res_sum,
    output logic                res_cout,
    output logic [63:0]         add_a,
    output logic [63:0]         add_b,
    output logic                add_cin,
    input  logic [63:0]         add_s,
    input  logic                add_cout
);

    localparam int W    = 64 * WORDS;
    localparam int IDXW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [IDXW-1:0] idx_reg;
    logic            carry_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;

    logic [63:0]     a_words [WORDS];
    logic [63:0]     b_words [WORDS];
    logic            last_word;

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_words
            assign a_words[gi] = a_reg[gi*64 +: 64];
            assign b_words[gi] = b_reg[gi*64 +: 64];
        end
    endgenerate

    assign last_word = (idx_reg == IDXW'(WORDS - 1));

    // The adder only sees real operands while sequencing; otherwise it idles at zero.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_reg == RUN) begin
            add_a   = a_words[idx_reg];
            add_b   = b_words[idx_reg];
            add_cin = carry_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B on capture, force carry-in.
                        a_reg     <= op_a;
                        b_reg     <= op_sub ? ~op_b : op_b;
                        carry_reg <= op_sub ? 1'b1 : op_cin;
                        idx_reg   <= '0;
                        in_ready  <= 1'b0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    res_sum[{idx_reg, 6'd0} +: 64] <= add_s;
                    carry_reg <= add_cout;
                    idx_reg   <= idx_reg + 1'b1;
                    if (last_word) begin
                        res_cout  <= add_cout;
                        out_valid <= 1'b1;
                        idx_reg   <= '0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Table-driven bench for multiword_adder_sequencer with a behavioural 64-bit adder
// standing in for the shared external adder.
module tb_multiword_adder_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 64 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic [63:0]  add_a;
    logic [63:0]  add_b;
    logic         add_cin;
    logic [63:0]  add_s;
    logic         add_cout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

    multiword_adder_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request at a negedge; it is accepted at the following posedge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input string name);
        @(negedge clk);
        check({name, ".in_ready_before"}, W'(in_ready), W'(1));
        op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from acceptance until out_valid rises (bounded).
    task automatic wait_result(input string name);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, ".latency"}, W'(cyc), W'(WORDS));
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, ".out_valid_after"}, W'(out_valid), W'(0));
        check({name, ".in_ready_after"}, W'(in_ready), W'(1));
    endtask

    task automatic run_vec(input vec_t v);
        start_op(v.a, v.b, v.cin, v.sub, v.name);
        wait_result(v.name);
        check({v.name, ".sum"}, res_sum, v.exp_sum);
        check({v.name, ".cout"}, W'(res_cout), W'(v.exp_cout));
        $display("op %-10s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d",
                 v.name, v.a[127:0], v.b[127:0], v.cin, v.sub, res_sum[127:0], res_cout);
        consume(v.name);
    endtask

    function automatic vec_t mk(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                input logic [W-1:0] es, input logic ec);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.exp_sum = es; v.exp_cout = ec;
        return v;
    endfunction

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] aa;
        logic [W-1:0] held;
        ones = '1;
        aa   = {WORDS{64'hAAAA_AAAA_AAAA_AAAA}};

        vecs[0] = mk("zero_aa",  '0, aa, 1'b0, 1'b0, aa, 1'b0);
        vecs[1] = mk("ones_c0",  ones, ones, 1'b0, 1'b0, {ones[W-1:1], 1'b0}, 1'b1);
        vecs[2] = mk("ones_c1",  ones, ones, 1'b1, 1'b0, ones, 1'b1);
        vecs[3] = mk("ripple",   W'({64'd1, 64'hFFFF_FFFF_FFFF_FFFF}), W'(1), 1'b0, 1'b0,
                     W'({64'd2, 64'd0}), 1'b0);
        vecs[4] = mk("sub_0m1",  '0, W'(1), 1'b0, 1'b1, ones, 1'b0);
        vecs[5] = mk("sub_5m3",  W'(5), W'(3), 1'b1, 1'b1, W'(2), 1'b1);
        vecs[6] = mk("add_cin",  W'(5), W'(3), 1'b1, 1'b0, W'(9), 1'b0);
        vecs[7] = mk("top_carry", {1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b0,
                     '0, 1'b1);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready",  W'(in_ready),  W'(1));
        check("rst.out_valid", W'(out_valid), W'(0));
        check("rst.res_sum",   res_sum,       '0);
        check("rst.res_cout",  W'(res_cout),  W'(0));
        check("rst.add_a",     W'(add_a),     '0);
        check("rst.add_cin",   W'(add_cin),   '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Stall in DONE; an in_valid pulse there must be ignored.
        start_op(W'(7), W'(8), 1'b0, 1'b0, "stall");
        wait_result("stall");
        held = res_sum;
        check("stall.sum", res_sum, W'(15));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) begin
                op_a = W'(100); op_b = W'(200); op_sub = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("stall.out_valid", W'(out_valid), W'(1));
            check("stall.in_ready",  W'(in_ready),  W'(0));
            check("stall.res_sum",   res_sum,       held);
        end
        in_valid = 1'b0;
        $display("op stall      held sum=%h for 10 cycles", res_sum[63:0]);
        consume("stall");
        repeat (6) @(posedge clk);
        #1;
        check("stall.no_new_op", W'(out_valid), W'(0));
        check("stall.sum_kept",  res_sum,       held);

        // Reset while sequencing word 2 aborts the operation.
        start_op(ones, W'(1), 1'b0, 1'b0, "abort");
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort.add_a_word2", W'(add_a), W'(64'hFFFF_FFFF_FFFF_FFFF));
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort.in_ready",  W'(in_ready),  W'(1));
        check("abort.out_valid", W'(out_valid), W'(0));
        check("abort.res_sum",   res_sum,       '0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("op abort      reset mid-run, sum=%h", res_sum[63:0]);
        run_vec(mk("post_rst", W'(1), W'(1), 1'b0, 1'b0, W'(2), 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
